// File: rtl/stall_controller_pkg.sv
// Shared types for the pipeline stall controller: ID/EX control-mux select
// and the memory-wait state encoding.
package controlmux;
    typedef enum logic {
        norm = 1'b0,
        zero = 1'b1
    } controlmux_sel_t;
endpackage

package rv32i_types;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        DMEM_WAIT = 2'd2
    } stallctl_state_t;
endpackage

// File: rtl/stall_controller_perf_counter.sv
// Free-running 32-bit event counter with synchronous clear; wraps modulo 2^32.
module perf_counter (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);
    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: freezes or bubbles the pipeline on memory
// waits and load-use hazards, and defers branch redirects taken during imem waits.
module stall_controller
    import controlmux::*;
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hd_stall_i,
    input  logic            br_taken_i,
    input  logic [31:0]     br_target_i,
    input  logic            imem_read_i,
    input  logic            imem_resp_i,
    input  logic            dmem_req_i,
    input  logic            dmem_resp_i,
    output logic            pc_write_o,
    output logic            if_id_write_o,
    output logic            id_ex_write_o,
    output logic            ex_mem_write_o,
    output logic            mem_wb_write_o,
    output logic            if_id_flush_o,
    output controlmux_sel_t id_ex_ctrl_sel_o,
    output logic            pc_redirect_o,
    output logic [31:0]     redirect_pc_o,
    output logic [31:0]     stall_cycles_o,
    output logic [31:0]     flush_count_o
);
    stallctl_state_t state_reg;
    stallctl_state_t state_next;
    logic            pending_reg;
    logic [31:0]     redirect_pc_reg;

    logic imem_busy;
    logic dmem_busy;
    logic mem_free;
    logic pending_fire;

    assign imem_busy = imem_read_i & ~imem_resp_i;
    assign dmem_busy = dmem_req_i & ~dmem_resp_i;
    assign mem_free  = ~imem_busy & ~dmem_busy;

    // A pending redirect is only ever created inside a wait, so it always
    // fires on the first free cycle after leaving a wait state.
    assign pending_fire = pending_reg & mem_free & (state_reg != RUN);

    always_comb begin
        state_next = RUN;
        if (dmem_busy) begin
            state_next = DMEM_WAIT;
        end else if (imem_busy) begin
            state_next = IMEM_WAIT;
        end
    end

    always_comb begin
        pc_write_o       = 1'b1;
        if_id_write_o    = 1'b1;
        id_ex_write_o    = 1'b1;
        ex_mem_write_o   = 1'b1;
        mem_wb_write_o   = 1'b1;
        if_id_flush_o    = 1'b0;
        id_ex_ctrl_sel_o = norm;
        pc_redirect_o    = 1'b0;
        redirect_pc_o    = redirect_pc_reg;

        if (dmem_busy) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            mem_wb_write_o = 1'b0;
        end else if (imem_busy) begin
            pc_write_o       = 1'b0;
            if_id_write_o    = 1'b0;
            id_ex_ctrl_sel_o = zero;
        end else if (br_taken_i) begin
            if_id_flush_o    = 1'b1;
            id_ex_ctrl_sel_o = zero;
            pc_redirect_o    = 1'b1;
            redirect_pc_o    = br_target_i;
        end else if (pending_fire) begin
            if_id_flush_o    = 1'b1;
            id_ex_ctrl_sel_o = zero;
            pc_redirect_o    = 1'b1;
        end else if (hd_stall_i) begin
            pc_write_o       = 1'b0;
            if_id_write_o    = 1'b0;
            id_ex_ctrl_sel_o = zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pending_reg     <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (imem_busy && !dmem_busy && br_taken_i) begin
                pending_reg     <= 1'b1;
                redirect_pc_reg <= br_target_i;
            end else if (pending_fire) begin
                pending_reg <= 1'b0;
            end
        end
    end

    perf_counter u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (~pc_write_o),
        .count (stall_cycles_o)
    );

    perf_counter u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (if_id_flush_o),
        .count (flush_count_o)
    );
endmodule
